// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, constants and helpers for the seven-segment scan controller.
//   state_t    : scan FSM states (BLANK gap between digits, SHOW lit slot)
//   BLANK_CODE : decoder code that turns every segment off
//   cnt_width  : width of the shared slot/gap counter
package seg_scan_pkg;

    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Wide enough to count to the longer of the two phases; never below 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: display-side bus of the scan controller.
//   load, digits, lz_en       : host -> controller (value strobe, packed BCD, zero suppression)
//   hex, an                   : controller -> decoder / anode drivers
//   load_ack, frame_done      : controller -> host status pulses
interface seg_scan_if #(parameter int NUM_DIGITS = 4);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    lz_en;
    logic [3:0]              hex;
    logic [NUM_DIGITS-1:0]   an;
    logic                    load_ack;
    logic                    frame_done;

    modport master (output load, digits, lz_en, input hex, an, load_ack, frame_done);
    modport slave  (input load, digits, lz_en, output hex, an, load_ack, frame_done);

endinterface

// File: rtl/seg_scan_lzmask.sv
// seg_scan_lzmask: leading-zero suppress mask.
//   digits : packed BCD value, digit 0 in bits [3:0]
//   lz_en  : enables suppression
//   mask   : bit k set when digit k and every higher digit are zero (digit 0 never set)
module seg_scan_lzmask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic zero;

    // Walk down from the MSB; the first non-zero digit stops all further suppression.
    always_comb begin
        mask = '0;
        zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero    = zero & (digits[4*k +: 4] == 4'h0);
            mask[k] = lz_en & zero;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_scan_if slave (load/digits/lz_en in; hex/an/load_ack/frame_done out)
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);

    localparam int CW = cnt_width(REFRESH_DIV, BLANK_CYC);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] shadow, active, active_nx;
    logic [3:0]              hex_q, hex_nx;
    logic [NUM_DIGITS-1:0]   an_q, an_nx, mask;
    logic                    ack_q, frame_q, frame_nx;

    // Mask is evaluated on the value that will be active, so a frame-boundary
    // swap (including the load bypass) is suppressed correctly on its first digit.
    seg_scan_lzmask #(.NUM_DIGITS(NUM_DIGITS)) u_lzmask (
        .digits(active_nx),
        .lz_en (bus.lz_en),
        .mask  (mask)
    );

    // Outputs are registered, so they are computed from the transition being taken.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 1'b1;
        idx_nx    = idx;
        active_nx = active;
        hex_nx    = hex_q;
        an_nx     = an_q;
        frame_nx  = 1'b0;
        if (state == BLANK) begin
            if (cnt == CW'(BLANK_CYC - 1)) begin
                state_nx = SHOW;
                cnt_nx   = '0;
                // Frame boundary: a load on this very edge bypasses the shadow.
                if (idx == '0)
                    active_nx = bus.load ? bus.digits : shadow;
                an_nx  = ~(NUM_DIGITS'(1) << idx);
                hex_nx = mask[idx] ? BLANK_CODE : active_nx[4*idx +: 4];
            end
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            idx_nx   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            an_nx    = '1;
            hex_nx   = BLANK_CODE;
            frame_nx = (idx == IW'(NUM_DIGITS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            active  <= '0;
            hex_q   <= BLANK_CODE;
            an_q    <= '1;
            ack_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            shadow  <= bus.load ? bus.digits : shadow;
            active  <= active_nx;
            hex_q   <= hex_nx;
            an_q    <= an_nx;
            ack_q   <= bus.load;
            frame_q <= frame_nx;
        end
    end

    assign bus.hex        = hex_q;
    assign bus.an         = an_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench for seg_scan_ctrl (4 digits, slot 6, frame 24).
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: timeline position since reset plus displayed/pending values.
    int          t;
    logic [15:0] m_shadow, m_frame;
    logic [3:0]  m_hex;
    logic        e_ack;
    int          fd_cnt;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_digit(input logic [15:0] v, input int k, input logic lz);
        logic [15:0] upper;
        upper = v >> (4 * k);
        if (lz && k > 0 && upper == 16'h0) return 4'hF;
        return upper[3:0];
    endfunction

    task automatic model_reset();
        t        = 0;
        m_shadow = '0;
        m_frame  = '0;
        m_hex    = 4'hF;
        e_ack    = 1'b0;
    endtask

    task automatic check_outputs();
        int pos, dg;
        logic [3:0] an_exp;
        pos    = t % 6;
        dg     = (t / 6) % 4;
        an_exp = (pos < 2) ? 4'hF : ~(4'b0001 << dg);
        chk("an", bus.an, an_exp);
        chk("hex", bus.hex, (pos < 2) ? 4'hF : m_hex);
        chk("frame_done", bus.frame_done, (t > 0 && t % 24 == 0));
        chk("load_ack", bus.load_ack, e_ack);
    endtask

    task automatic step();
        @(posedge clk);
        if (t % 24 == 1) m_frame = bus.load ? bus.digits : m_shadow;
        if (t % 6 == 1) m_hex = exp_digit(m_frame, (t / 6) % 4, bus.lz_en);
        e_ack = bus.load;
        if (bus.load) m_shadow = bus.digits;
        t++;
        #1;
        if (bus.frame_done) fd_cnt++;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load   = 1'b1;
        bus.digits = v;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.digits = '0;
        bus.lz_en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();

        fd_cnt = 0;
        run(24);
        chk("fd_count_frame0", fd_cnt, 1);
        run(6);

        do_load(16'h0427);
        run(50);

        bus.lz_en = 1'b1;
        do_load(16'h0009);
        run(48);
        do_load(16'h0000);
        run(48);

        bus.lz_en = 1'b0;
        while (t % 24 != 1) step();
        do_load(16'h1234);
        chk("bypass_hex", bus.hex, 4'h4);
        run(30);

        repeat (300) begin
            bus.load   = ($urandom_range(0, 7) == 0);
            bus.digits = 16'($urandom);
            bus.lz_en  = 1'($urandom);
            step();
        end
        bus.load = 1'b0;

        while (t % 24 != 15) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", bus.an, 4'hF);
        chk("async_rst_hex", bus.hex, 4'hF);
        chk("async_rst_ack", bus.load_ack, 0);
        chk("async_rst_fd", bus.frame_done, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
        run(26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
